control_sequencer: RTL

//  Hardwired Moore control unit for the single-bus CPU datapath (CPUproject). Replaces bench-driven

---
 rtl/control_sequencer_if.sv | 39 +++
 rtl/control_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the single-bus datapath.
// The sequencer (master) drives every strobe; the datapath (slave) returns
// IR contents, the memory-done handshake and the halt request.
interface control_sequencer_if #(
    parameter int OPW = 5
);
    logic [31:0]    IR;
    logic           Mem_done;
    logic           Stop;

    logic           PCout, Zlowout, ZHighout, MDRout;
    logic           MARin, PCin, MDRin, IRin, Yin;
    logic           ZLowIn, ZHighIn, HIin, LOin;
    logic           IncPC, Read;
    logic           Gra, Grb, Grc, Rin, Rout;
    logic [OPW-1:0] ALU_op;
    logic           Run;
    logic           Illegal;

    modport master (
        input  IR, Mem_done, Stop,
        output PCout, Zlowout, ZHighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin,
        output ZLowIn, ZHighIn, HIin, LOin,
        output IncPC, Read,
        output Gra, Grb, Grc, Rin, Rout,
        output ALU_op, Run, Illegal
    );

    modport slave (
        output IR, Mem_done, Stop,
        input  PCout, Zlowout, ZHighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin,
        input  ZLowIn, ZHighIn, HIin, LOin,
        input  IncPC, Read,
        input  Gra, Grb, Grc, Rin, Rout,
        input  ALU_op, Run, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU: fetch (T0-T2),
// decode (T3), then ALU / MUL-DIV / NOP / HALT execute steps, ending in a
// zero-output boundary cycle where a halt request is honoured.
// Outputs depend only on the state (plus the IR opcode in T3/A4/M4), so
// Clear forcing RESET zeroes every strobe immediately.
module control_sequencer #(
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  Clock,
    input  logic                  Clear,
    control_sequencer_if.master   bus
);
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, A4, A5, M4, M5, M6, BND, HALTED, FAULT
    } state_t;

    state_t         state, next_state;
    logic [CW-1:0]  wait_cnt;
    logic [OPW-1:0] opcode;

    assign opcode = bus.IR[31 -: OPW];

    // State register; Clear drops straight to RESET from any state.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= RESET;
        else        state <= next_state;
    end

    // Memory wait counter: runs only while T1 keeps stalling, else held at 0.
    // A zero count in T1 also marks the first T1 cycle (PCin window).
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)                                  wait_cnt <= '0;
        else if (state == T1 && next_state == T1)    wait_cnt <= wait_cnt + 1'b1;
        else                                         wait_cnt <= '0;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        next_state   = state;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.ZHighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.ALU_op   = '0;
        bus.Illegal  = 1'b0;
        bus.Run      = !(state inside {RESET, HALTED, FAULT});

        unique case (state)
            RESET: next_state = T0;
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLowIn = 1'b1;
                next_state = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = (wait_cnt == '0);
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.Mem_done)
                    next_state = T2;
                else if (wait_cnt == CW'(MEM_TIMEOUT - 1))
                    next_state = FAULT;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                next_state = T3;
            end
            T3: begin
                case (opcode)
                    5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                    5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
                        bus.Grb    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Yin    = 1'b1;
                        next_state = A4;
                    end
                    5'b01100, 5'b01101: begin
                        bus.Gra    = 1'b1;
                        bus.Rout   = 1'b1;
                        bus.Yin    = 1'b1;
                        next_state = M4;
                    end
                    5'b11010: next_state = BND;
                    5'b11011: next_state = HALTED;
                    default: begin
                        bus.Illegal = 1'b1;
                        next_state  = BND;
                    end
                endcase
            end
            A4: begin
                bus.Grc    = 1'b1;
                bus.Rout   = 1'b1;
                bus.ALU_op = opcode;
                bus.ZLowIn = 1'b1;
                next_state = A5;
            end
            A5: begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                next_state  = BND;
            end
            M4: begin
                bus.Grb     = 1'b1;
                bus.Rout    = 1'b1;
                bus.ALU_op  = opcode;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = 1'b1;
                next_state  = M5;
            end
            M5: begin
                bus.Zlowout = 1'b1;
                bus.LOin    = 1'b1;
                next_state  = M6;
            end
            M6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                next_state   = BND;
            end
            BND:     next_state = bus.Stop ? HALTED : T0;
            HALTED:  next_state = HALTED;
            FAULT:   next_state = FAULT;
            default: next_state = RESET;
        endcase
    end
endmodule
